// File: rtl/cbfp_pkg.sv
// Shared types and sizing constants for the CBFP control unit and datapath.
package cbfp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } cbfp_state_e;

    localparam int CBFP_FRAME_CYCLES = 32;
    localparam int CBFP_BLK_CYCLES   = 8;

    // Counter width able to index n positions; never narrower than one bit.
    function automatic int cbfp_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CBFP_BEAT_W   = cbfp_cnt_w(CBFP_FRAME_CYCLES);
    localparam int CBFP_BLKOFF_W = cbfp_cnt_w(CBFP_BLK_CYCLES);
    localparam int CBFP_BLKIDX_W = cbfp_cnt_w(CBFP_FRAME_CYCLES / CBFP_BLK_CYCLES);

endpackage

// File: rtl/cbfp_ctrl_dly.sv
// Parametrised 1-bit shift register with synchronous active-low reset.
module cbfp_ctrl_dly #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/cu_cbfp_ctrl.sv
// CBFP stage controller: frame fill FSM, block-min strobes and delayed drain/shift schedule.
// Optional build macro CU_CBFP_OVF_ERR_EN enables premature frame-start detection on ovf_err.
module cu_cbfp_ctrl
    import cbfp_pkg::*;
#(
    parameter int FRAME_CYCLES = CBFP_FRAME_CYCLES,
    parameter int BLK_CYCLES   = CBFP_BLK_CYCLES,
    parameter int SHIFT_LAT    = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic alert_cbfp,
    output logic mag_en,
    output logic min_4s_en,
    output logic min_fin_en,
    output logic mux_sel,
    output logic bit_shift_en,
    output logic [$clog2(FRAME_CYCLES/BLK_CYCLES)-1:0] blk_idx,
    output logic valid_out,
    output logic ovf_err
);
    localparam int CNT_W = cbfp_cnt_w(FRAME_CYCLES);
    localparam int OFF_W = cbfp_cnt_w(BLK_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(BLK_CYCLES - 1);

    cbfp_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mag_en_q;
    logic             min_4s_en_q;
    logic             blk_end_q;
    logic             min_fin_en_q;
    logic             last_beat;

    assign last_beat = (state_q == FILL) && (cnt_q == LAST_BEAT);

    // A new frame is taken from IDLE or on the last FILL beat, giving gapless frames.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alert_cbfp) begin
                        state_q  <= FILL;
                        cnt_q    <= '0;
                        mag_en_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (last_beat) begin
                        cnt_q <= '0;
                        if (!alert_cbfp) begin
                            state_q  <= IDLE;
                            mag_en_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    mag_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Block-final minimum latches one cycle after the last 4-sample minimum of the block.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            min_4s_en_q  <= 1'b0;
            blk_end_q    <= 1'b0;
            min_fin_en_q <= 1'b0;
        end else begin
            min_4s_en_q  <= mag_en_q;
            blk_end_q    <= mag_en_q && (cnt_q[OFF_W-1:0] == LAST_OFF);
            min_fin_en_q <= blk_end_q;
        end
    end

    cbfp_ctrl_dly #(.STAGES(BLK_CYCLES + 2)) u_fill_dly (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (mag_en_q),
        .q_o  (bit_shift_en)
    );

    cbfp_ctrl_dly #(.STAGES(SHIFT_LAT)) u_vld_dly (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (bit_shift_en),
        .q_o  (valid_out)
    );

    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             par_q, par_d;

    // Drain position wraps per frame; bank parity never restarts except on reset.
    always_comb begin
        dcnt_d = dcnt_q;
        par_d  = par_q;
        if (bit_shift_en) begin
            dcnt_d = (dcnt_q == LAST_BEAT) ? '0 : dcnt_q + CNT_W'(1);
            if (dcnt_q[OFF_W-1:0] == LAST_OFF) begin
                par_d = ~par_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dcnt_q <= '0;
            par_q  <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            par_q  <= par_d;
        end
    end

`ifdef CU_CBFP_OVF_ERR_EN
    logic ovf_err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= alert_cbfp && (state_q == FILL) && !last_beat;
        end
    end

    assign ovf_err = ovf_err_q;
`else
    assign ovf_err = 1'b0;
`endif

    assign mag_en     = mag_en_q;
    assign min_4s_en  = min_4s_en_q;
    assign min_fin_en = min_fin_en_q;
    assign mux_sel    = par_q;
    assign blk_idx    = dcnt_q[CNT_W-1:OFF_W];

endmodule

// File: tb/tb_cu_cbfp_ctrl.sv
// Scoreboard bench for cu_cbfp_ctrl: default instance (F=32,B=8) and a small one (F=16,B=4).
module tb_cu_cbfp_ctrl;

    typedef struct packed {
        logic       mag;
        logic       min4;
        logic       fin;
        logic       bse;
        logic       mux;
        logic [1:0] blk;
        logic       vld;
        logic       ovf;
    } ov_t;

    typedef struct {
        int  scen;
        int  cyc;
        ov_t e32;
        ov_t e16;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       alert = 1'b0;
    logic       alert16 = 1'b0;

    logic       mag_a, min4_a, fin_a, mux_a, bse_a, vld_a, ovf_a;
    logic [1:0] blk_a;
    logic       mag_b, min4_b, fin_b, mux_b, bse_b, vld_b, ovf_b;
    logic [1:0] blk_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cu_cbfp_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .alert_cbfp   (alert),
        .mag_en       (mag_a),
        .min_4s_en    (min4_a),
        .min_fin_en   (fin_a),
        .mux_sel      (mux_a),
        .bit_shift_en (bse_a),
        .blk_idx      (blk_a),
        .valid_out    (vld_a),
        .ovf_err      (ovf_a)
    );

    cu_cbfp_ctrl #(.FRAME_CYCLES(16), .BLK_CYCLES(4), .SHIFT_LAT(1)) dut16 (
        .clk          (clk),
        .rstn         (rstn),
        .alert_cbfp   (alert16),
        .mag_en       (mag_b),
        .min_4s_en    (min4_b),
        .min_fin_en   (fin_b),
        .mux_sel      (mux_b),
        .bit_shift_en (bse_b),
        .blk_idx      (blk_b),
        .valid_out    (vld_b),
        .ovf_err      (ovf_b)
    );

    // Expected waveform of nf back-to-back frames accepted in cycle t0 (timing table formulas).
    function automatic ov_t frame_exp(input int c, input int t0, input int nf,
                                      input int f, input int b, input int sl);
        ov_t o;
        int  n, g;
        o = '0;
        n = nf * f;
        o.mag  = (c >= t0 + 1) && (c <= t0 + n);
        o.min4 = (c >= t0 + 2) && (c <= t0 + n + 1);
        for (int k = 0; k < n / b; k++) begin
            if (c == t0 + 2 + (k + 1) * b) o.fin = 1'b1;
        end
        o.bse = (c >= t0 + 3 + b) && (c <= t0 + 2 + b + n);
        if (o.bse) begin
            g     = (c - (t0 + 3 + b)) / b;
            o.mux = g[0];
            o.blk = 2'(g % (f / b));
        end
        o.vld = (c >= t0 + 3 + b + sl) && (c <= t0 + 2 + b + n + sl);
        return o;
    endfunction

    function automatic bit ov_match(input ov_t a, input ov_t e);
        ov_t m;
        m = '1;
        if (!e.bse) begin
            m.mux = 1'b0;
            m.blk = 2'b00;
        end
        return ((a ^ e) & m) == '0;
    endfunction

    function automatic exp_t build_exp(input int s, input int c);
        exp_t x;
        x.scen = s;
        x.cyc  = c;
        x.e32  = '0;
        x.e16  = '0;
        case (s)
            1: x.e32 = frame_exp(c, 10, 1, 32, 8, 1);
            2: x.e32 = frame_exp(c, 10, 2, 32, 8, 1);
            3: begin
                x.e32 = frame_exp(c, 10, 1, 32, 8, 1);
`ifdef CU_CBFP_OVF_ERR_EN
                x.e32.ovf = (c == 21) || (c == 42);
`endif
            end
            4: x.e32 = (c <= 30) ? frame_exp(c, 10, 1, 32, 8, 1)
                                 : frame_exp(c, 40, 1, 32, 8, 1);
            5: x.e16 = frame_exp(c, 0, 1, 16, 4, 1);
            default: ;
        endcase
        return x;
    endfunction

    task automatic run_scen(input int s, input int ncyc);
        rstn    = 1'b0;
        alert   = 1'b0;
        alert16 = 1'b0;
        repeat (3) @(posedge clk);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            rstn    = !((s == 4) && (c >= 30) && (c <= 33));
            alert   = 1'b0;
            alert16 = 1'b0;
            case (s)
                1: alert = (c == 10);
                2: alert = (c == 10) || (c == 42);
                3: alert = (c == 10) || (c == 20) || (c == 41);
                4: alert = (c == 10) || (c == 40);
                5: alert16 = (c == 0);
                default: ;
            endcase
            exp_q.push_back(build_exp(s, c));
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        ov_t  a32, a16;
        if (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            a32 = {mag_a, min4_a, fin_a, bse_a, mux_a, blk_a, vld_a, ovf_a};
            a16 = {mag_b, min4_b, fin_b, bse_b, mux_b, blk_b, vld_b, ovf_b};
            checks++;
            if (!ov_match(a32, x.e32)) begin
                errors++;
                $display("FAIL dut32 scen=%0d cyc=%0d got=%b exp=%b (mag,min4,fin,bse,mux,blk,vld,ovf)",
                         x.scen, x.cyc, a32, x.e32);
            end
            checks++;
            if (!ov_match(a16, x.e16)) begin
                errors++;
                $display("FAIL dut16 scen=%0d cyc=%0d got=%b exp=%b (mag,min4,fin,bse,mux,blk,vld,ovf)",
                         x.scen, x.cyc, a16, x.e16);
            end
        end
    end

    initial begin
        run_scen(1, 60);
        run_scen(2, 92);
        run_scen(3, 60);
        run_scen(4, 90);
        run_scen(5, 30);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cu_cbfp_ctrl.md
# cu_cbfp_ctrl

Parametrised control unit for a convergent block-floating-point (CBFP) stage in the FFT pipeline. It succeeds the fixed stage-0 CBFP controller. It accepts a one-cycle frame-start pulse from the preceding butterfly stage and sequences the CBFP datapath through magnitude detection, 4-sample minimum, block-final minimum, ping-pong buffer select, and normalising shift. It adds three things the fixed controller lacks: configurable frame and block length, gapless back-to-back frames, and detection of premature frame starts.

## Interface
- FRAME_CYCLES, 32: input beats per frame (16 lanes per beat); multiple of BLK_CYCLES.
- BLK_CYCLES, 8: beats per CBFP normalisation block; power of two, ≥2.
- SHIFT_LAT, 1: datapath shifter latency in cycles, ≥1.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- alert_cbfp  in  1  frame-start pulse; beat 0 is on the datapath input in the same cycle.
- mag_en  out  1  qualifies the registered input beat for the magnitude/leading-sign unit.
- min_4s_en  out  1  enables the 4-sample minimum stage.
- min_fin_en  out  1  one-cycle pulse that latches the block-final minimum.
- mux_sel  out  1  ping-pong bank being read and shifted. The write bank is ~mux_sel.
- bit_shift_en  out  1  enables normalising shift of the current read block.
- blk_idx  out  $clog2(FRAME_CYCLES/BLK_CYCLES)  block index within the frame during bit_shift_en.
- valid_out  out  1  output-data valid to the next FFT module.
- ovf_err  out  1  one-cycle pulse when a premature alert_cbfp is ignored.

## Operation
- Input FSM has two states, IDLE and FILL.
  - IDLE→FILL when alert_cbfp is sampled high. The beat counter is loaded to 0.
  - FILL holds for FRAME_CYCLES cycles, then returns to IDLE.
  - If alert_cbfp is sampled on the last FILL cycle, the FSM re-enters FILL with no gap.
- The accepting edge is t0. Beat n is presented in cycle t0+n.
- alert_cbfp in cycles t0+1 … t0+FRAME_CYCLES−1 is ignored. ovf_err pulses the next cycle and the schedule is unchanged.
- Drain side: a delayed copy of the fill strobe, plus a free-running block counter.
  - Block parity is global and continues across frames, so mux_sel alternates across frame boundaries.
  - blk_idx restarts at 0 with each frame.
- All outputs are registered. Every output resets to 0, and the counters and FSM reset to IDLE/0.
- Reset mid-frame discards all in-flight work. The first frame after release starts on mux_sel=0.

## Timing
With F = FRAME_CYCLES and B = BLK_CYCLES, for block k = 0 … F/B−1:
- mag_en: t0+1 … t0+F.
- min_4s_en: t0+2 … t0+F+1.
- min_fin_en: single pulse at t0+2+(k+1)·B.
- bit_shift_en: t0+3+(k+1)·B … t0+2+(k+2)·B, i.e. continuous from t0+3+B to t0+2+B+F.
  - mux_sel = global block parity for the whole window.
  - blk_idx = k for the whole window.
- valid_out: bit_shift_en delayed by SHIFT_LAT cycles.
- Latency from beat 0 to the first valid_out is B+3+SHIFT_LAT.
- Back-to-back frames produce continuous mag_en, min_4s_en, bit_shift_en and valid_out.
- Simultaneous alert and last-beat: accepted. Simultaneous alert and rstn low: reset wins.

## Configuration
- CU_CBFP_OVF_ERR_EN defined: premature-alert detection is built and ovf_err behaves as above.
- Not defined: detection logic is removed, ovf_err is tied 0, and premature alerts are still ignored.

## Structure
- Package cbfp_pkg holds:
  - the state enum {IDLE, FILL};
  - default FRAME_CYCLES and BLK_CYCLES constants;
  - count-width helper constants shared with the CBFP datapath.
- One sub-module, cbfp_ctrl_dly: a parametrised 1-bit shift register with synchronous reset.
  - It is instantiated for the fill-to-drain delay (B+2 stages).
  - It is instantiated again for the SHIFT_LAT stages of valid_out.

## Test plan
- **Single frame, defaults (F=32, B=8, SHIFT_LAT=1), alert at cycle 10:**
  - mag_en 11–42, min_4s_en 12–43.
  - min_fin_en pulses at 20, 28, 36, 44.
  - bit_shift_en 21–52, with mux_sel 0/1/0/1 and blk_idx 0/1/2/3 per 8 cycles.
  - valid_out 22–53.
- **Back-to-back, second alert at 42:**
  - mag_en continuous 11–74.
  - mux_sel continues alternating for 8 blocks.
  - valid_out continuous 22–85, ovf_err never asserted.
- **Premature alert at cycle 20 during frame from 10:**
  - ovf_err pulses at 21.
  - All other outputs are identical to the first scenario.
- **rstn low at edge 30 mid-frame:**
  - All outputs are 0 from cycle 31.
  - After release, a new alert yields the first-scenario waveform shifted in time, with mux_sel starting at 0.
- **F=16, B=4, alert at cycle 0:**
  - min_fin_en pulses at 6, 10, 14, 18.
  - bit_shift_en 7–22, valid_out 8–23.
- **CU_CBFP_OVF_ERR_EN undefined, premature alert at cycle 20:**
  - ovf_err stays 0.
  - The schedule is unchanged.
